seq_fetch: RTL and testbench

Fetch stage of the sequential Y86-64 processor. It holds the architectural PC register and loads it with the next-PC value computed downstream (`PC_updated`) when the current instruction retires. It reads the instruction byte by byte from a byte-wide instruction-memory port using a request/ready handshake. It then presents the decoded fields (icode, ifun, rA, rB, valC, valP) and a status code to decode/execute until the instruction is retired.

---
 rtl/seq_fetch.sv | 108 ++++++++++
 tb/tb_seq_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_fetch.sv
// seq_fetch: Y86-64 sequential fetch stage reading instructions byte-serially over a req/ready port
module seq_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter longint unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] PC_updated,
  input  logic        instr_done,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [7:0]  imem_rdata,
  output logic [63:0] PC,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic [2:0]  stat
);
  localparam logic [2:0] FETCH_OP = 3'd0, FETCH_REG = 3'd1, FETCH_C = 3'd2, VALID = 3'd3, HALTED = 3'd4;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  logic [2:0]  state, k;
  logic [3:0]  b_icode, b_ifun, op_len, off;
  logic        ifun_bad, bad, has_reg, has_c, fetching, oob, accept;
  logic [64:0] sum;
  always_comb begin
    b_icode  = imem_rdata[7:4];
    b_ifun   = imem_rdata[3:0];
    op_len   = b_icode inside {4'h7, 4'h8} ? 4'd9 :
               b_icode inside {4'h3, 4'h4, 4'h5} ? 4'd10 :
               b_icode inside {4'h2, 4'h6, 4'hA, 4'hB} ? 4'd2 : 4'd1;
    ifun_bad = b_icode inside {4'h2, 4'h7} ? b_ifun > 4'd6 :
               b_icode == 4'h6 ? b_ifun > 4'd3 : b_ifun != 4'd0;
    bad      = b_icode > 4'hB || ifun_bad;
    has_reg  = b_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    has_c    = b_icode inside {4'h7, 4'h8};
    off      = state == FETCH_REG ? 4'd1 :
               state == FETCH_C ? (icode inside {4'h3, 4'h4, 4'h5} ? 4'd2 : 4'd1) + {1'b0, k} : 4'd0;
    sum      = {1'b0, PC} + 65'(off);
    oob      = sum >= 65'(IMEM_BYTES);
    fetching = state inside {FETCH_OP, FETCH_REG, FETCH_C};
    accept   = imem_req && imem_ready;
  end
  assign instr_valid = state == VALID;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH_OP;
      k         <= 3'd0;
      PC        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      icode     <= 4'h0;
      ifun      <= 4'h0;
      rA        <= 4'hF;
      rB        <= 4'hF;
      valC      <= 64'h0;
      valP      <= RESET_PC;
      stat      <= AOK;
    end else if (fetching && !imem_req) begin
      // every byte address is range-checked before it is ever put on the bus
      if (oob) begin
        stat  <= ADR;
        state <= VALID;
      end else begin
        imem_req  <= 1'b1;
        imem_addr <= sum[63:0];
      end
    end else if (accept) begin
      imem_req <= 1'b0;
      case (state)
        FETCH_OP: begin
          icode <= b_icode;
          ifun  <= b_ifun;
          valP  <= PC + 64'(op_len);
          stat  <= bad ? INS : (b_icode == 4'h0 ? HLT : AOK);
          state <= bad || b_icode == 4'h0 ? VALID : has_reg ? FETCH_REG : has_c ? FETCH_C : VALID;
        end
        FETCH_REG: begin
          rA    <= imem_rdata[7:4];
          rB    <= imem_rdata[3:0];
          state <= icode inside {4'h3, 4'h4, 4'h5} ? FETCH_C : VALID;
        end
        default: begin
          valC[{k, 3'b000} +: 8] <= imem_rdata;
          k     <= k + 3'd1;
          state <= k == 3'd7 ? VALID : FETCH_C;
        end
      endcase
    end else if (state == VALID && instr_done) begin
      if (stat == AOK) begin
        PC    <= PC_updated;
        valP  <= PC_updated;
        icode <= 4'h0;
        ifun  <= 4'h0;
        rA    <= 4'hF;
        rB    <= 4'hF;
        valC  <= 64'h0;
        state <= FETCH_OP;
      end else begin
        state <= HALTED;
      end
    end
  end
endmodule

// File: tb/tb_seq_fetch.sv
// tb_seq_fetch: directed scoreboard bench for seq_fetch with a byte-memory responder
module tb_seq_fetch;
  logic        clk, reset, instr_done, imem_req, imem_ready, instr_valid;
  logic [63:0] PC_updated, imem_addr, PC, valC, valP;
  logic [7:0]  imem_rdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic [2:0]  stat;
  seq_fetch dut (
    .clk(clk), .reset(reset), .PC_updated(PC_updated), .instr_done(instr_done),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .PC(PC), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_valid(instr_valid), .stat(stat)
  );
  typedef struct {
    logic [63:0] pc;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [2:0]  stat;
    bit          dc;
  } rec_t;
  rec_t        exp_q[$];
  logic [63:0] req_log[$];
  logic [7:0]  mem[1024];
  int          vectors = 0, miscompares = 0, lat = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(string n, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic push(logic [63:0] pc, logic [3:0] ic, logic [3:0] fn, logic [3:0] ra, logic [3:0] rb,
                      logic [63:0] vc, logic [63:0] vp, logic [2:0] st, bit dc);
    rec_t r;
    r.pc = pc; r.icode = ic; r.ifun = fn; r.ra = ra; r.rb = rb;
    r.valc = vc; r.valp = vp; r.stat = st; r.dc = dc;
    exp_q.push_back(r);
  endtask
  task automatic responder();
    int w = 0;
    bit hv = 0;
    logic [63:0] ha = 0;
    forever begin
      @(negedge clk);
      if (imem_req && hv) check("addr_stable", imem_addr, ha);
      if (imem_req && imem_addr >= 64'd1024) begin
        vectors++;
        miscompares++;
        $display("FAIL addr_range: imem_addr=%h required < 400", imem_addr);
      end
      if (imem_req && !reset) begin
        if (w >= lat) begin
          imem_ready = 1'b1;
          imem_rdata = imem_addr < 64'd1024 ? mem[imem_addr[9:0]] : 8'h00;
          req_log.push_back(imem_addr);
          w = 0;
          hv = 0;
        end else begin
          imem_ready = 1'b0;
          w++;
          hv = 1;
          ha = imem_addr;
        end
      end else begin
        imem_ready = 1'b0;
        w = 0;
        hv = 0;
      end
    end
  endtask
  task automatic monitor();
    bit pv = 0;
    rec_t e;
    forever begin
      @(negedge clk);
      if (instr_valid && !pv) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL record: unexpected instr_valid at PC=%h, none expected", PC);
        end else begin
          e = exp_q.pop_front();
          if (PC !== e.pc || icode !== e.icode || ifun !== e.ifun || rA !== e.ra || rB !== e.rb ||
              valC !== e.valc || (!e.dc && valP !== e.valp) || stat !== e.stat) begin
            miscompares++;
            $display("FAIL record: got PC=%h ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h stat=%0d expected PC=%h ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h stat=%0d",
                     PC, icode, ifun, rA, rB, valC, valP, stat,
                     e.pc, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.stat);
          end
        end
      end
      pv = instr_valid;
    end
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 300; i++) begin
      if (instr_valid) return;
      @(negedge clk);
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_valid: instr_valid=0 after 300 cycles, required 1");
  endtask
  task automatic check_log(string n, logic [63:0] first, int cnt);
    bit ok = req_log.size() == cnt;
    for (int i = 0; ok && i < cnt; i++) ok = req_log[i] === first + 64'(i);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d requests starting %h, required %0d from %h",
               n, req_log.size(), req_log.size() > 0 ? req_log[0] : 64'hx, cnt, first);
    end
  endtask
  task automatic retire(logic [63:0] nxt);
    req_log.delete();
    PC_updated = nxt;
    instr_done = 1'b1;
    @(negedge clk);
    instr_done = 1'b0;
  endtask
  task automatic do_reset();
    instr_done = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    req_log.delete();
    reset = 1'b0;
  endtask
  initial begin
    int cnt;
    reset = 1'b1; instr_done = 1'b0; PC_updated = 64'h0; imem_ready = 1'b0; imem_rdata = 8'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h10;
    begin
      logic [7:0] irm[10] = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
      logic [7:0] jmp[9]  = '{8'h70, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      for (int i = 0; i < 10; i++) mem[16 + i] = irm[i];
      for (int i = 0; i < 9; i++) mem[32 + i] = jmp[i];
    end
    mem[64] = 8'h00; mem[1022] = 8'h30; mem[1023] = 8'hF3; mem[96] = 8'hC0;
    fork
      responder();
      monitor();
    join_none
    repeat (2) @(negedge clk);
    check("rst_req", 64'(imem_req), 0);
    check("rst_valid", 64'(instr_valid), 0);
    check("rst_pc", PC, 0);
    check("rst_icode_ifun", {icode, ifun}, 0);
    check("rst_ra_rb", {rA, rB}, 64'hFF);
    check("rst_valc", valC, 0);
    check("rst_valp", valP, 0);
    check("rst_stat", 64'(stat), 1);
    push(0, 4'h1, 4'h0, 4'hF, 4'hF, 0, 1, 3'd1, 0);
    req_log.delete();
    reset = 1'b0;
    wait_valid(); check_log("nop_reqs", 0, 1); retire(64'h10);
    push(64'h10, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h1A, 3'd1, 0);
    wait_valid(); check_log("irmovq_reqs", 64'h10, 10); retire(64'h20);
    lat = 3;
    push(64'h20, 4'h7, 4'h0, 4'hF, 4'hF, 64'h8877665544332211, 64'h29, 3'd1, 0);
    wait_valid(); check_log("jmp_reqs", 64'h20, 9);
    lat = 0;
    push(64'h40, 4'h0, 4'h0, 4'hF, 4'hF, 0, 64'h41, 3'd2, 0);
    retire(64'h40);
    @(negedge clk);
    check("retire_next_req", 64'(imem_req), 1);
    check("retire_next_addr", imem_addr, 64'h40);
    wait_valid(); check_log("halt_reqs", 64'h40, 1);
    instr_done = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (imem_req || instr_valid) cnt++;
    end
    check("halted_quiet", 64'(cnt), 0);
    check("halted_stat", 64'(stat), 2);
    check("halted_pc", PC, 64'h40);
    push(0, 4'h1, 4'h0, 4'hF, 4'hF, 0, 1, 3'd1, 0);
    do_reset();
    wait_valid(); check_log("restart_reqs", 0, 1); retire(64'd1022);
    push(64'd1022, 4'h3, 4'h0, 4'hF, 4'h3, 0, 64'd1032, 3'd3, 0);
    wait_valid(); check_log("adr_reqs", 64'd1022, 2); retire(0);
    push(0, 4'h1, 4'h0, 4'hF, 4'hF, 0, 1, 3'd1, 0);
    do_reset();
    wait_valid(); retire(64'h60);
    push(64'h60, 4'hC, 4'h0, 4'hF, 4'hF, 0, 0, 3'd4, 1);
    wait_valid(); check_log("ins_reqs", 64'h60, 1); retire(0);
    push(0, 4'h1, 4'h0, 4'hF, 4'hF, 0, 1, 3'd1, 0);
    do_reset();
    wait_valid(); retire(64'h10);
    lat = 1;
    cnt = 0;
    while (!(imem_req && imem_addr == 64'h14) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_reached_byte5", 64'(cnt < 200), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_req", 64'(imem_req), 0);
    check("abort_pc", PC, 0);
    check("abort_valid", 64'(instr_valid), 0);
    push(0, 4'h1, 4'h0, 4'hF, 4'hF, 0, 1, 3'd1, 0);
    req_log.delete();
    lat = 0;
    reset = 1'b0;
    wait_valid(); check_log("post_abort_reqs", 0, 1);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
